// File: rtl/rom_download_router.sv
// rom_download_router
//   Routes ROM bytes from data_io onto up to NPORTS sdram write ports. Each
//   port owns an address window and a packing mode. A port is written with a
//   toggle req/ack handshake. When a target port is still busy, the byte goes
//   into a single holding stage and ioctl_wait stalls the host. Once the ROM
//   download ends and every port has drained, rom_loaded is set. core_reset
//   is then released RESET_HOLD cycles later.
//
// Ports
//   clk_sys, reset        : clock, synchronous active-high reset
//   ioctl_*               : data_io download interface (ioctl_wait is the stall)
//   port_req / port_ack   : per-port toggle handshake
//   port_we               : per-port write enable, high while a ROM download is active
//   port_a / port_ds      : per-port word address and byte strobes {upper, lower}
//   port_d                : per-port data word {byte, byte}
//   status_reset          : external core reset request
//   rom_loaded            : sticky, set when a ROM download has completed and drained
//   core_reset            : stretched reset for the game core
//   err_overflow          : sticky, a byte was dropped because the holding stage was full
//
// FSM states
//   state   | meaning
//   S_IDLE  | no ROM download in progress
//   S_LOAD  | ROM download active, bytes are accepted
//   S_DRAIN | download ended, waiting for the holding stage and all ports to go idle
module rom_download_router #(
  parameter int                   NPORTS     = 2,
  parameter logic [7:0]           ROM_INDEX  = 8'd0,
  parameter logic [NPORTS*25-1:0] PORT_BASE  = {25'h0C000, 25'h0},
  parameter logic [NPORTS*25-1:0] PORT_SIZE  = {25'h04000, 25'h0C000},
  parameter logic [NPORTS-1:0]    PORT_MODE  = 2'b10,
  parameter logic [NPORTS*5-1:0]  PORT_SPLIT = {5'd13, 5'd0},
  parameter int                   RESET_HOLD = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic                 status_reset,
  output logic                 ioctl_wait,
  output logic [NPORTS-1:0]    port_req,
  input  logic [NPORTS-1:0]    port_ack,
  output logic [NPORTS-1:0]    port_we,
  output logic [NPORTS*23-1:0] port_a,
  output logic [NPORTS*2-1:0]  port_ds,
  output logic [NPORTS*16-1:0] port_d,
  output logic                 rom_loaded,
  output logic                 core_reset,
  output logic                 err_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t            state;
  logic              wr_last;
  logic              dl_last;
  logic [7:0]        idx_last;

  logic              hold_valid;
  logic [NPORTS-1:0] hold_mask;
  // Only the low 24 address bits feed the offset arithmetic, so that is all we keep.
  logic [23:0]       hold_addr;
  logic [7:0]        hold_byte;

  logic [15:0]       hold_cnt;

  logic              ev;
  logic              dl_rise_rom;
  logic              dl_fall_rom;
  logic [NPORTS-1:0] match;
  logic [NPORTS-1:0] busy;
  logic              hold_issue;
  logic              new_ok;
  logic              issue_new;
  logic              to_hold;
  logic              overflow;
  logic [NPORTS-1:0] issue_mask;
  logic [23:0]       sel_addr;
  logic [7:0]        sel_byte;
  logic              cause;

  logic [22:0]       pk_a  [NPORTS];
  logic [1:0]        pk_ds [NPORTS];

  assign ev          = ioctl_wr & ~wr_last & ioctl_download & (ioctl_index == ROM_INDEX);
  assign dl_rise_rom = ioctl_download & ~dl_last & (ioctl_index == ROM_INDEX);
  assign dl_fall_rom = ~ioctl_download & dl_last & (idx_last == ROM_INDEX);

  assign busy       = port_req ^ port_ack;
  assign hold_issue = hold_valid && ((hold_mask & busy) == '0);
  assign new_ok     = ev && !hold_valid && (match != '0);
  assign issue_new  = new_ok && ((match & busy) == '0);
  assign to_hold    = new_ok && !issue_new;
  assign overflow   = ev && hold_valid;
  assign issue_mask = hold_issue ? hold_mask : (issue_new ? match : '0);

  // Whenever the stage is occupied it is the only thing that can issue, so
  // packing always works from the stage contents in that case.
  assign sel_addr = hold_valid ? hold_addr : ioctl_addr[23:0];
  assign sel_byte = hold_valid ? hold_byte : ioctl_dout;

  assign ioctl_wait = hold_valid;
  assign port_we    = {NPORTS{state != S_IDLE}};

  assign cause = reset | status_reset | ~rom_loaded | (state != S_IDLE);

  always_comb begin
    logic [25:0] base26;
    logic [25:0] end26;
    logic [23:0] off;
    logic [23:0] lo_mask;
    logic [4:0]  s;
    base26  = '0;
    end26   = '0;
    off     = '0;
    lo_mask = '0;
    s       = '0;
    for (int p = 0; p < NPORTS; p++) begin
      // 26-bit compare so base + size cannot wrap.
      base26   = {1'b0, PORT_BASE[p*25 +: 25]};
      end26    = base26 + {1'b0, PORT_SIZE[p*25 +: 25]};
      match[p] = ({1'b0, ioctl_addr} >= base26) && ({1'b0, ioctl_addr} < end26);
      off      = sel_addr - PORT_BASE[p*25 +: 24];
      s        = PORT_SPLIT[p*5 +: 5];
      if (PORT_MODE[p]) begin
        // Split-interleave: bit S selects the byte lane and is squeezed out of the word address.
        lo_mask  = (24'd1 << s) - 24'd1;
        pk_a[p]  = 23'(((off >> (s + 5'd1)) << s) | (off & lo_mask));
        pk_ds[p] = {off[s], ~off[s]};
      end else begin
        pk_a[p]  = off[23:1];
        pk_ds[p] = {off[0], ~off[0]};
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last      <= 1'b0;
      dl_last      <= 1'b0;
      idx_last     <= '0;
      state        <= S_IDLE;
      port_req     <= port_ack;
      port_a       <= '0;
      port_ds      <= '0;
      port_d       <= '0;
      hold_valid   <= 1'b0;
      hold_mask    <= '0;
      hold_addr    <= '0;
      hold_byte    <= '0;
      err_overflow <= 1'b0;
      rom_loaded   <= 1'b0;
    end else begin
      wr_last  <= ioctl_wr;
      dl_last  <= ioctl_download;
      idx_last <= ioctl_index;

      for (int p = 0; p < NPORTS; p++) begin
        if (issue_mask[p]) begin
          port_req[p]         <= ~port_req[p];
          port_a[p*23 +: 23]  <= pk_a[p];
          port_ds[p*2 +: 2]   <= pk_ds[p];
          port_d[p*16 +: 16]  <= {sel_byte, sel_byte};
        end
      end

      if (hold_issue) begin
        hold_valid <= 1'b0;
      end else if (to_hold) begin
        hold_valid <= 1'b1;
        hold_mask  <= match;
        hold_addr  <= ioctl_addr[23:0];
        hold_byte  <= ioctl_dout;
      end

      if (overflow) err_overflow <= 1'b1;

      if (dl_rise_rom) begin
        state      <= S_LOAD;
        rom_loaded <= 1'b0;
      end else begin
        case (state)
          S_LOAD: begin
            if (dl_fall_rom) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (!hold_valid && (busy == '0)) begin
              rom_loaded <= 1'b1;
              state      <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end

    // core_reset drops on the edge where the counter reaches zero, i.e.
    // RESET_HOLD cycles after the cause first reads low.
    if (cause) begin
      hold_cnt   <= 16'(RESET_HOLD);
      core_reset <= 1'b1;
    end else if (hold_cnt != 16'd0) begin
      hold_cnt   <= hold_cnt - 16'd1;
      core_reset <= (hold_cnt > 16'd1);
    end else begin
      core_reset <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_download_router.sv
module tb_rom_download_router;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        status_reset;
  logic        ioctl_wait;
  logic [1:0]  port_req;
  logic [1:0]  port_ack;
  logic [1:0]  port_we;
  logic [45:0] port_a;
  logic [3:0]  port_ds;
  logic [31:0] port_d;
  logic        rom_loaded;
  logic        core_reset;
  logic        err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side expectation of each port's outputs.
  logic [1:0]  exp_req;
  logic [22:0] ea  [2];
  logic [1:0]  eds [2];
  logic [15:0] ed  [2];

  rom_download_router dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .status_reset   (status_reset),
    .ioctl_wait     (ioctl_wait),
    .port_req       (port_req),
    .port_ack       (port_ack),
    .port_we        (port_we),
    .port_a         (port_a),
    .port_ds        (port_ds),
    .port_d         (port_d),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
    .err_overflow   (err_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    port_ack = 2'b10;
    tick(3);
    n_tests++;
    if (port_req !== 2'b10) begin n_fail++; $display("FAIL reset_req: got %b expected %b", port_req, 2'b10); end
    n_tests++;
    if ({port_a, port_ds, port_d} !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h expected 0", port_a, port_ds, port_d); end
    n_tests++;
    if ({ioctl_wait, err_overflow, rom_loaded, core_reset} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0001", {ioctl_wait, err_overflow, rom_loaded, core_reset});
    end
    reset = 1'b0;
    tick();
    exp_req = 2'b10;
    for (int p = 0; p < 2; p++) begin ea[p] = '0; eds[p] = '0; ed[p] = '0; end
  endtask

  task automatic test_routing;
    logic [24:0] t_addr [7];
    logic [7:0]  t_data [7];
    int          t_port [7];
    logic [22:0] t_a    [7];
    logic [1:0]  t_ds   [7];
    t_addr[0] = 25'h00003; t_data[0] = 8'h5A; t_port[0] = 0; t_a[0] = 23'h000001; t_ds[0] = 2'b10;
    t_addr[1] = 25'h0E001; t_data[1] = 8'hC3; t_port[1] = 1; t_a[1] = 23'h000001; t_ds[1] = 2'b10;
    t_addr[2] = 25'h0BFFF; t_data[2] = 8'hA1; t_port[2] = 0; t_a[2] = 23'h005FFF; t_ds[2] = 2'b10;
    t_addr[3] = 25'h0C000; t_data[3] = 8'hB2; t_port[3] = 1; t_a[3] = 23'h000000; t_ds[3] = 2'b01;
    t_addr[4] = 25'h10000; t_data[4] = 8'h77; t_port[4] = 2; t_a[4] = 23'h000000; t_ds[4] = 2'b00;
    t_addr[5] = 25'h0D234; t_data[5] = 8'h4E; t_port[5] = 1; t_a[5] = 23'h001234; t_ds[5] = 2'b01;
    t_addr[6] = 25'h0F234; t_data[6] = 8'h9F; t_port[6] = 1; t_a[6] = 23'h001234; t_ds[6] = 2'b10;

    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    n_tests++;
    if (port_we !== 2'b11) begin n_fail++; $display("FAIL load_we: got %b expected 11", port_we); end
    n_tests++;
    if (core_reset !== 1'b1) begin n_fail++; $display("FAIL load_core_reset: got %b expected 1", core_reset); end

    for (int i = 0; i < 7; i++) begin
      ioctl_addr = t_addr[i];
      ioctl_dout = t_data[i];
      ioctl_wr = 1'b1;
      if (t_port[i] < 2) begin
        exp_req[t_port[i]] = ~exp_req[t_port[i]];
        ea[t_port[i]]  = t_a[i];
        eds[t_port[i]] = t_ds[i];
        ed[t_port[i]]  = {t_data[i], t_data[i]};
      end
      tick();
      n_tests++;
      if (port_req !== exp_req) begin n_fail++; $display("FAIL route%0d_req: got %b expected %b", i, port_req, exp_req); end
      n_tests++;
      if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL route%0d_wait: got %b expected 0", i, ioctl_wait); end
      n_tests++;
      if (port_a !== {ea[1], ea[0]}) begin n_fail++; $display("FAIL route%0d_a: got %h expected %h", i, port_a, {ea[1], ea[0]}); end
      n_tests++;
      if (port_ds !== {eds[1], eds[0]}) begin n_fail++; $display("FAIL route%0d_ds: got %b expected %b", i, port_ds, {eds[1], eds[0]}); end
      n_tests++;
      if (port_d !== {ed[1], ed[0]}) begin n_fail++; $display("FAIL route%0d_d: got %h expected %h", i, port_d, {ed[1], ed[0]}); end
      ioctl_wr = 1'b0;
      port_ack = exp_req;
      tick();
    end
  endtask

  task automatic test_back_pressure;
    ioctl_addr = 25'h00010; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    exp_req[0] = ~exp_req[0];
    ea[0] = 23'h000008; eds[0] = 2'b01; ed[0] = 16'h1111;
    tick();
    n_tests++;
    if ({port_req, port_a[22:0], port_ds[1:0], port_d[15:0]} !== {exp_req, ea[0], eds[0], ed[0]}) begin
      n_fail++; $display("FAIL bp_first: got %b %h %b %h expected %b %h %b %h", port_req, port_a[22:0], port_ds[1:0], port_d[15:0], exp_req, ea[0], eds[0], ed[0]);
    end
    ioctl_wr = 1'b0;
    tick();

    ioctl_addr = 25'h00021; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    tick();
    n_tests++;
    if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL bp_wait_rise: got %b expected 1", ioctl_wait); end
    n_tests++;
    if ({port_req, port_a[22:0]} !== {exp_req, ea[0]}) begin
      n_fail++; $display("FAIL bp_held: got %b %h expected %b %h", port_req, port_a[22:0], exp_req, ea[0]);
    end
    n_tests++;
    if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL bp_no_overflow: got %b expected 0", err_overflow); end
    ioctl_wr = 1'b0;
    tick();

    ioctl_addr = 25'h00030; ioctl_dout = 8'h33; ioctl_wr = 1'b1;
    tick();
    n_tests++;
    if ({err_overflow, ioctl_wait} !== 2'b11) begin n_fail++; $display("FAIL bp_overflow: got %b expected 11", {err_overflow, ioctl_wait}); end
    ioctl_wr = 1'b0;
    tick();

    port_ack = exp_req;
    exp_req[0] = ~exp_req[0];
    ea[0] = 23'h000010; eds[0] = 2'b10; ed[0] = 16'h2222;
    tick();
    n_tests++;
    if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL bp_wait_fall: got %b expected 0", ioctl_wait); end
    n_tests++;
    if ({port_req, port_a, port_ds, port_d} !== {exp_req, ea[1], ea[0], eds[1], eds[0], ed[1], ed[0]}) begin
      n_fail++; $display("FAIL bp_release: got %b %h %b %h expected %b %h %b %h", port_req, port_a, port_ds, port_d, exp_req, {ea[1], ea[0]}, {eds[1], eds[0]}, {ed[1], ed[0]});
    end
    port_ack = exp_req;
    tick(3);
    n_tests++;
    if ({port_req, port_a[22:0], port_d[15:0]} !== {exp_req, ea[0], ed[0]}) begin
      n_fail++; $display("FAIL bp_dropped: got %b %h %h expected %b %h %h", port_req, port_a[22:0], port_d[15:0], exp_req, ea[0], ed[0]);
    end
    n_tests++;
    if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: got %b expected 1", err_overflow); end
  endtask

  task automatic test_drain;
    ioctl_addr = 25'h00002; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
    exp_req[0] = ~exp_req[0];
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick(3);
    n_tests++;
    if ({rom_loaded, port_we, core_reset} !== 4'b0111) begin
      n_fail++; $display("FAIL drain_pending: got %b expected 0111", {rom_loaded, port_we, core_reset});
    end
    port_ack = exp_req;
    tick();
    n_tests++;
    if (rom_loaded !== 1'b1) begin n_fail++; $display("FAIL drain_loaded: got %b expected 1", rom_loaded); end
    n_tests++;
    if (port_we !== 2'b00) begin n_fail++; $display("FAIL drain_we: got %b expected 00", port_we); end
    tick(15);
    n_tests++;
    if (core_reset !== 1'b1) begin n_fail++; $display("FAIL hold_15: got %b expected 1", core_reset); end
    tick();
    n_tests++;
    if (core_reset !== 1'b0) begin n_fail++; $display("FAIL hold_16: got %b expected 0", core_reset); end

    status_reset = 1'b1;
    tick(2);
    n_tests++;
    if (core_reset !== 1'b1) begin n_fail++; $display("FAIL status_high: got %b expected 1", core_reset); end
    status_reset = 1'b0;
    tick(15);
    n_tests++;
    if (core_reset !== 1'b1) begin n_fail++; $display("FAIL status_15: got %b expected 1", core_reset); end
    tick();
    n_tests++;
    if ({core_reset, rom_loaded} !== 2'b01) begin n_fail++; $display("FAIL status_16: got %b expected 01", {core_reset, rom_loaded}); end
  endtask

  task automatic test_reset_mid;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    n_tests++;
    if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL mid_loaded_clear: got %b expected 0", rom_loaded); end
    ioctl_addr = 25'h00004; ioctl_dout = 8'h55; ioctl_wr = 1'b1;
    exp_req[0] = ~exp_req[0];
    tick();
    n_tests++;
    if (port_req !== exp_req) begin n_fail++; $display("FAIL mid_req: got %b expected %b", port_req, exp_req); end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    reset = 1'b1;
    tick();
    n_tests++;
    if (port_req !== port_ack) begin n_fail++; $display("FAIL mid_resync: got %b expected %b", port_req, port_ack); end
    n_tests++;
    if ({rom_loaded, core_reset, ioctl_wait, port_a, port_ds, port_d} !== {3'b010, 82'h0}) begin
      n_fail++; $display("FAIL mid_state: got %b %b %b %h expected 0 1 0 0", rom_loaded, core_reset, ioctl_wait, port_a);
    end
    reset = 1'b0;
    tick();
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    n_tests++;
    if (port_we !== 2'b00) begin n_fail++; $display("FAIL idx1_we: got %b expected 00", port_we); end
    ioctl_addr = 25'h00003; ioctl_dout = 8'h66; ioctl_wr = 1'b1;
    tick();
    n_tests++;
    if ({port_req, port_a, ioctl_wait} !== {port_ack, 46'h0, 1'b0}) begin
      n_fail++; $display("FAIL idx1_quiet: got %b %h %b expected %b 0 0", port_req, port_a, ioctl_wait, port_ack);
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick(3);
    n_tests++;
    if ({rom_loaded, core_reset, port_we} !== 4'b0100) begin
      n_fail++; $display("FAIL idx1_after: got %b expected 0100", {rom_loaded, core_reset, port_we});
    end
  endtask

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    status_reset = 1'b0;
    port_ack = 2'b00;
    test_reset();
    test_routing();
    test_back_pressure();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_download_router.md
Name: rom_download_router

Overview:
- Generalised ROM download controller between data_io and the sdram ports.
- Routes each ioctl byte to up to NPORTS sdram write ports by address window.
- Per-port packing is byte-lane or split-interleave. Uses the toggle req/ack handshake with back-pressure.
- Generates rom_loaded and a stretched core reset once all ports have drained.

Parameters:
- NPORTS, 2, number of sdram write ports (1..4)
- ROM_INDEX, 8'd0, ioctl_index value accepted as ROM data
- PORT_BASE, {25'h0C000,25'h0}, packed NPORTS x 25: window start byte address, port 0 in LSBs
- PORT_SIZE, {25'h04000,25'h0C000}, packed NPORTS x 25: window length in bytes, nonzero
- PORT_MODE, 2'b10, packed NPORTS x 1: 0 = byte-lane, 1 = split-interleave
- PORT_SPLIT, {5'd13,5'd0}, packed NPORTS x 5: interleave bit of the window offset (mode 1 only), range 1..22
- RESET_HOLD, 16, cycles core_reset stays high after its last cause clears

Ports:
- clk_sys in 1: system clock
- reset in 1: synchronous, active-high
- ioctl_download in 1: download active
- ioctl_index in 8: download index
- ioctl_wr in 1: byte strobe, level; its rising edge is the event
- ioctl_addr in 25: byte address
- ioctl_dout in 8: byte data
- status_reset in 1: OSD/button reset request
- ioctl_wait out 1: stall request to data_io
- port_req out NPORTS: toggle request, one per port
- port_ack in NPORTS: toggle acknowledge, one per port
- port_we out NPORTS: write enable per port, = accepted download active
- port_a out NPORTS*23: word address per port
- port_ds out NPORTS*2: byte strobes per port, {upper, lower}
- port_d out NPORTS*16: data per port, {byte, byte}
- rom_loaded out 1: sticky, set when a ROM download completes and drains
- core_reset out 1: active-high reset for the game core
- err_overflow out 1: sticky, a byte arrived while the holding stage was full

Behaviour:
- Reset values:
  - port_req <= port_ack (resynchronises the handshake; ports show idle).
  - port_a, port_ds, port_d = 0.
  - ioctl_wait = 0, err_overflow = 0, rom_loaded = 0.
  - core_reset = 1; hold counter loaded with RESET_HOLD.
  - Holding stage empty; wr_last = 0.
- Event: wr_last registered each cycle. An event occurs in cycle N when ioctl_wr & ~wr_last & ioctl_download & (ioctl_index == ROM_INDEX).
- Port p matches when PORT_BASE[p] <= ioctl_addr < PORT_BASE[p]+PORT_SIZE[p]. Compare at 26 bits so there is no wrap. Offset = ioctl_addr - PORT_BASE[p].
- Mode 0 packing: a = offset[23:1]; ds = {offset[0], ~offset[0]}.
- Mode 1 packing: a = {offset[23:S+1], offset[S-1:0]} with S = PORT_SPLIT[p]; ds = {offset[S], ~offset[S]}.
- Both modes: d = {ioctl_dout, ioctl_dout}.
- A port is idle when port_req[p] == port_ack[p].
- Matching ports may be multiple (overlapping windows). All are written with the same byte, each with its own packing.
- Issue when every matching port is idle at cycle N: port_a/ds/d latched and port_req toggled, all visible at N+1. Latency is 1 cycle.
- Busy case: if any matching port is busy, the byte, address and match mask go into the single holding stage, and ioctl_wait = 1 from N+1. Each cycle the stage is re-checked. When all its ports are idle, it issues as above, empties, and drops ioctl_wait in the same cycle as the req toggle.
- Holding stage full and a new event occurs: byte dropped, err_overflow set (sticky until reset).
- No matching port: byte dropped silently. No req, no wait.
- port_a/ds/d of a port change only on that port's issue. They are stable while it is busy.
- Completion: on a falling edge of ioctl_download with the last index == ROM_INDEX, the FSM goes to DRAIN.
- FSM states:
  - IDLE: waiting for download. Moves to LOAD when ioctl_download rises with ROM_INDEX.
  - LOAD: accepting bytes. Moves to DRAIN on the download falling edge.
  - DRAIN: waits until the holding stage is empty and all ports are idle, then sets rom_loaded and moves to IDLE.
  - A new download (ROM_INDEX) in any state moves to LOAD and clears rom_loaded.
- Downloads with other indices are ignored entirely. They cause no state change and no reset.
- core_reset cause = reset | status_reset | ~rom_loaded | (state != IDLE).
  - While the cause is high, core_reset = 1 and the counter reloads to RESET_HOLD.
  - Once the cause is low, the counter decrements each cycle; core_reset = 0 when it reaches 0.
  - core_reset therefore falls exactly RESET_HOLD cycles after the cause first reads 0.
- Reset mid-download: holding stage discarded, FSM to IDLE, rom_loaded = 0. The host must restart the download.

Test Plan:
- Default params; download index 0, byte 0x5A at addr 0x00003 -> port_req[0] toggles 1 cycle after the edge; port_a0 = 0x000001, ds0 = 2'b10, d0 = 0x5A5A; port 1 req unchanged.
- Byte 0xC3 at addr 0x0E001 -> port 1 only; offset 0x2001, S = 13 -> port_a1 = 0x000001, ds1 = 2'b10; port 0 untouched.
- Hold port_ack[0] so port 0 stays busy; send two bytes for port 0 -> ioctl_wait rises at N+1 for the second byte. Release ack -> second byte issues and ioctl_wait falls in the same cycle. A third byte sent while waiting -> err_overflow = 1, byte not issued.
- Download of addr 0x10000 (outside both windows) -> no req on either port, ioctl_wait = 0.
- Full download, then ioctl_download falls with port 0 busy -> rom_loaded stays 0 until ack. rom_loaded = 1 the cycle after drain. core_reset falls exactly RESET_HOLD = 16 cycles later. status_reset pulse -> core_reset high, then 16 cycles after release.
- Assert reset mid-download with a request outstanding -> port_req equals port_ack next cycle; rom_loaded = 0; core_reset = 1; index-1 download afterwards -> no port activity.
